jt6295_adpcm_mux: RTL



---
 rtl/jt6295_adpcm_mux.sv | 123 ++++++++++++
 1 files changed

// File: rtl/jt6295_adpcm_mux.sv
// Time-multiplexed OKI ADPCM decoder for CH voices with per-voice attenuation
// and a saturating mixer; one voice slot is served per cen pulse.
module jt6295_adpcm_mux #(
  parameter  int CH = 4,
  parameter  int OW = 14,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 cen,
  output logic [CW-1:0]        ch_sel,
  input  logic [3:0]           data,
  input  logic                 en,
  input  logic                 kon,
  input  logic [3:0]           att,
  output logic signed [OW-1:0] sound,
  output logic                 sample_ok
);
  localparam int AW = 12 + $clog2(CH) + 1;
  localparam logic signed [31:0] SMAX = (32'sd1 <<< (OW-1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -(32'sd1 <<< (OW-1));

  logic signed [11:0]   s_mem   [CH];
  logic        [5:0]    idx_mem [CH];
  logic signed [AW-1:0] acc;

  logic signed [11:0]   s_old, s_new, v, v_eff;
  logic        [5:0]    idx_old, idx_new;
  logic        [10:0]   step;
  logic        [12:0]   diff;
  logic signed [13:0]   s_ext, d_ext, s_sum;
  logic signed [7:0]    idx_sum;
  logic        [5:0]    gain;
  logic signed [18:0]   prod;
  logic signed [AW-1:0] sum;
  logic signed [31:0]   sum32;
  logic signed [OW-1:0] sat_val;
  logic                 last;

  function automatic logic [10:0] lut(input logic [5:0] i);
    case (i)
      6'd0:  lut = 11'd16;   6'd1:  lut = 11'd17;   6'd2:  lut = 11'd19;   6'd3:  lut = 11'd21;
      6'd4:  lut = 11'd23;   6'd5:  lut = 11'd25;   6'd6:  lut = 11'd28;   6'd7:  lut = 11'd31;
      6'd8:  lut = 11'd34;   6'd9:  lut = 11'd37;   6'd10: lut = 11'd41;   6'd11: lut = 11'd45;
      6'd12: lut = 11'd50;   6'd13: lut = 11'd55;   6'd14: lut = 11'd60;   6'd15: lut = 11'd66;
      6'd16: lut = 11'd73;   6'd17: lut = 11'd80;   6'd18: lut = 11'd88;   6'd19: lut = 11'd97;
      6'd20: lut = 11'd107;  6'd21: lut = 11'd118;  6'd22: lut = 11'd130;  6'd23: lut = 11'd143;
      6'd24: lut = 11'd157;  6'd25: lut = 11'd173;  6'd26: lut = 11'd190;  6'd27: lut = 11'd209;
      6'd28: lut = 11'd230;  6'd29: lut = 11'd253;  6'd30: lut = 11'd279;  6'd31: lut = 11'd307;
      6'd32: lut = 11'd337;  6'd33: lut = 11'd371;  6'd34: lut = 11'd408;  6'd35: lut = 11'd449;
      6'd36: lut = 11'd494;  6'd37: lut = 11'd544;  6'd38: lut = 11'd598;  6'd39: lut = 11'd658;
      6'd40: lut = 11'd724;  6'd41: lut = 11'd796;  6'd42: lut = 11'd876;  6'd43: lut = 11'd963;
      6'd44: lut = 11'd1060; 6'd45: lut = 11'd1166; 6'd46: lut = 11'd1282; 6'd47: lut = 11'd1411;
      default: lut = 11'd1552;
    endcase
  endfunction

  function automatic logic [5:0] gain_of(input logic [3:0] a);
    case (a)
      4'd0: gain_of = 6'd32; 4'd1: gain_of = 6'd22; 4'd2: gain_of = 6'd16;
      4'd3: gain_of = 6'd11; 4'd4: gain_of = 6'd8;  4'd5: gain_of = 6'd6;
      4'd6: gain_of = 6'd4;  4'd7: gain_of = 6'd3;  4'd8: gain_of = 6'd2;
      default: gain_of = 6'd0;
    endcase
  endfunction

  always_comb begin
    // key-on restarts the predictor before this slot's nibble is applied
    s_old   = kon ? 12'sd0 : s_mem[ch_sel];
    idx_old = kon ? 6'd0   : idx_mem[ch_sel];
    step    = lut(idx_old);
    diff    = 13'(step >> 3) + (data[2] ? 13'(step) : 13'd0)
            + (data[1] ? 13'(step >> 1) : 13'd0) + (data[0] ? 13'(step >> 2) : 13'd0);
    s_ext   = {{2{s_old[11]}}, s_old};
    d_ext   = {1'b0, diff};
    s_sum   = data[3] ? s_ext - d_ext : s_ext + d_ext;
    if (s_sum > 14'sd2047)       s_new = 12'sd2047;
    else if (s_sum < -14'sd2048) s_new = -12'sd2048;
    else                         s_new = s_sum[11:0];
    idx_sum = data[2] ? $signed({2'b0, idx_old}) + $signed({5'b0, data[1:0], 1'b0}) + 8'sd2
                      : $signed({2'b0, idx_old}) - 8'sd1;
    if (idx_sum < 8'sd0)       idx_new = 6'd0;
    else if (idx_sum > 8'sd48) idx_new = 6'd48;
    else                       idx_new = idx_sum[5:0];
    gain    = gain_of(att);
    prod    = s_new * $signed({1'b0, gain});
    v       = 12'(prod >>> 5);
    v_eff   = en ? v : 12'sd0;
    sum     = ((ch_sel == '0) ? '0 : acc) + {{(AW-12){v_eff[11]}}, v_eff};
    sum32   = 32'(sum);
    if (sum32 > SMAX)      sat_val = SMAX[OW-1:0];
    else if (sum32 < SMIN) sat_val = SMIN[OW-1:0];
    else                   sat_val = sum32[OW-1:0];
    last    = (ch_sel == CW'(CH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel    <= '0;
      sound     <= '0;
      sample_ok <= 1'b0;
      acc       <= '0;
      for (int i = 0; i < CH; i++) begin
        s_mem[i]   <= '0;
        idx_mem[i] <= '0;
      end
    end else begin
      sample_ok <= 1'b0;
      if (cen) begin
        if (en) begin
          s_mem[ch_sel]   <= s_new;
          idx_mem[ch_sel] <= idx_new;
        end
        acc    <= sum;
        ch_sel <= last ? '0 : CW'(ch_sel + 1'b1);
        if (last) begin
          sound     <= sat_val;
          sample_ok <= 1'b1;
        end
      end
    end
  end
endmodule
